// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with one-shot and auto-reload interrupt modes.
// Optional CTRL prescaler field is enabled by defining TIMER_PRESCALE_EN.
module timer_dev #(
    parameter int PSC_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } stateT;

    stateT       state;
    stateT       nextState;
    logic        en;
    logic [1:0]  mode;
    logic        im;
    logic [31:0] preset;
    logic [31:0] count;
    logic        pend;
    logic        ctrlWr;
    logic        presetWr;
    logic        modeAuto;
    logic        cntDone;
    logic        decTick;
    logic        setPend;
    logic        clrEn;
    logic [31:0] ctrlRd;
    logic        unusedDin;

    assign ctrlWr   = WE && (Addr == 2'b00);
    assign presetWr = WE && (Addr == 2'b01);
    assign modeAuto = (mode == 2'b01);
    assign cntDone  = (count <= 32'd1);
    assign unusedDin = ^Din[31:4];

`ifdef TIMER_PRESCALE_EN
    logic [PSC_W-1:0] psc;
    logic [PSC_W-1:0] pscCnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            psc    <= '0;
            pscCnt <= '0;
        end else begin
            if (ctrlWr)
                psc <= Din[8 +: PSC_W];
            if (state == LOAD)
                pscCnt <= '0;
            else if (state == CNT && en)
                pscCnt <= decTick ? '0 : pscCnt + 1'b1;
        end
    end

    assign decTick = (pscCnt == psc);

    always_comb begin
        ctrlRd = '0;
        ctrlRd[3:0] = {im, mode, en};
        ctrlRd[8 +: PSC_W] = psc;
    end
`else
    localparam int unusedPscW = PSC_W;

    assign decTick = 1'b1;
    assign ctrlRd  = {28'd0, im, mode, en};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= nextState;
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: if (en) nextState = LOAD;
            LOAD: nextState = CNT;
            CNT: begin
                if (!en)
                    nextState = IDLE;
                else if (cntDone)
                    nextState = INT;
            end
            INT: nextState = modeAuto ? LOAD : IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        setPend = (state == CNT) && en && cntDone && !modeAuto;
        clrEn   = (state == INT) && !modeAuto;
        IRQ     = im && (modeAuto ? (state == INT) : pend);
    end

    // Software writes win over the FSM's EN clear; FSM PEND set wins over write clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en     <= 1'b0;
            mode   <= 2'b00;
            im     <= 1'b0;
            preset <= '0;
            count  <= '0;
            pend   <= 1'b0;
        end else begin
            if (ctrlWr) begin
                en   <= Din[0];
                mode <= Din[2:1];
                im   <= Din[3];
            end else if (clrEn) begin
                en <= 1'b0;
            end
            if (presetWr)
                preset <= Din;
            if (state == LOAD)
                count <= preset;
            else if (state == CNT && en) begin
                if (!cntDone) begin
                    if (decTick)
                        count <= count - 32'd1;
                end else begin
                    count <= '0;
                end
            end
            if (setPend)
                pend <= 1'b1;
            else if (ctrlWr || presetWr)
                pend <= 1'b0;
        end
    end

    always_comb begin
        case (Addr)
            2'b00:   Dout = ctrlRd;
            2'b01:   Dout = preset;
            2'b10:   Dout = count;
            default: Dout = '0;
        endcase
    end

endmodule
